// File: rtl/mixcolumns_seq.sv
// AES MixColumns sequencer: feeds four columns of a 128-bit state through one
// shared column unit and reassembles the results; bypass skips mixing.
module mixcolumns_seq #(
  parameter int COL_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_bypass,
  input  logic [127:0] i_state,
  output logic [31:0]  o_col,
  output logic         o_col_valid,
  input  logic [31:0]  i_col_res,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         r_fsm, w_fsm_nxt;
  logic [127:0]   r_state;
  logic [127:0]   r_out;
  logic [1:0]     r_issue_cnt;
  logic [1:0]     r_cap_cnt;
  logic [COL_LAT:1] r_vld_pipe;
  logic           w_accept;
  logic           w_cap;

  assign w_accept = i_valid && o_ready;
  // Tap at the far end of the delay line lines up with the unit's result.
  assign w_cap    = r_vld_pipe[COL_LAT];
  assign o_state  = r_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fsm <= IDLE;
    else      r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    o_col_valid = 1'b0;
    o_col       = '0;
    case (r_fsm)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_fsm_nxt = i_bypass ? DONE : ISSUE;
      end
      ISSUE: begin
        o_col_valid = 1'b1;
        // Column k sits at bits [127-32k -: 32]; 3-k == ~k for a 2-bit k.
        o_col       = r_state[{~r_issue_cnt, 5'b0} +: 32];
        if (r_issue_cnt == 2'd3) w_fsm_nxt = WAIT;
      end
      WAIT: begin
        if (w_cap && r_cap_cnt == 2'd3) w_fsm_nxt = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= '0;
      r_out       <= '0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_vld_pipe  <= '0;
    end else begin
      if (w_accept) begin
        r_state <= i_state;
        if (i_bypass) r_out <= i_state;
      end
      if (o_col_valid) r_issue_cnt <= r_issue_cnt + 2'd1;
      r_vld_pipe[1] <= o_col_valid;
      for (int i = 2; i <= COL_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      if (w_cap) begin
        r_out[{~r_cap_cnt, 5'b0} +: 32] <= i_col_res;
        r_cap_cnt <= r_cap_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Scoreboard bench for mixcolumns_seq: one DUT with COL_LAT=1, one with COL_LAT=3,
// each fed by a behavioural column unit; a monitor checks every output handshake.
module tb_mixcolumns_seq;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          vld = '0;
  logic [1:0]          ordy;
  logic [1:0]          byp = '0;
  logic [1:0][127:0]   ist = '0;
  logic [1:0][31:0]    col;
  logic [1:0]          cvld;
  logic [1:0][31:0]    cres;
  logic [1:0]          ovld;
  logic [1:0]          irdy = '1;
  logic [1:0][127:0]   ost;

  always #5 clk = ~clk;

  mixcolumns_seq #(.COL_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_valid(vld[0]), .o_ready(ordy[0]), .i_bypass(byp[0]),
    .i_state(ist[0]), .o_col(col[0]), .o_col_valid(cvld[0]), .i_col_res(cres[0]),
    .o_valid(ovld[0]), .i_ready(irdy[0]), .o_state(ost[0]));

  mixcolumns_seq #(.COL_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .i_valid(vld[1]), .o_ready(ordy[1]), .i_bypass(byp[1]),
    .i_state(ist[1]), .o_col(col[1]), .o_col_valid(cvld[1]), .i_col_res(cres[1]),
    .o_valid(ovld[1]), .i_ready(irdy[1]), .o_state(ost[1]));

  // GF(2^8) reference arithmetic
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input int m);
    case (m)
      2:       return xt(a);
      3:       return xt(a) ^ a;
      default: return a;
    endcase
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    int          base [4] = '{2, 3, 1, 1};
    logic [7:0]  a [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    r = '0;
    for (int row = 0; row < 4; row++) begin
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < 4; i++) acc ^= gm(a[i], base[(i - row + 4) % 4]);
      r[31-8*row -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[127-32*k -: 32] = mixcol(s[127-32*k -: 32]);
    return r;
  endfunction

  // Behavioural shared column unit; garbage on idle cycles must be ignored.
  logic [31:0] cp0 [4];
  logic [31:0] cp1 [4];
  always @(posedge clk) begin
    cp0[0] <= cvld[0] ? mixcol(col[0]) : $urandom;
    cp1[0] <= cvld[1] ? mixcol(col[1]) : $urandom;
    for (int i = 1; i < 4; i++) begin
      cp0[i] <= cp0[i-1];
      cp1[i] <= cp1[i-1];
    end
  end
  assign cres[0] = cp0[0];
  assign cres[1] = cp1[2];

  typedef struct {
    logic [127:0] data;
    int           lat;
    int           ncol;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic [1:0] vprev = '0;
  logic [1:0] chk_rdy = '0;
  int   ncol_seen [2] = '{0, 0};
  int   last_hs [2] = '{0, 0};
  bit   rnd_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (cvld[d]) ncol_seen[d]++;
        else check("col_idle_zero", 128'(col[d]), 128'd0);
        if (vld[d] && ordy[d]) begin
          acc_q.push_back(cyc);
          ncol_seen[d] = 0;
        end
        if (ovld[d]) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            check("unexpected_output", 128'(ovld[d]), 128'd0);
          end else begin
            if (!vprev[d]) check("latency", 128'(cyc - acc_q[0]), 128'(exp_q[0].lat));
            check("o_state", ost[d], exp_q[0].data);
            check("o_ready_busy", 128'(ordy[d]), 128'd0);
            if (irdy[d]) begin
              check("col_pulses", 128'(ncol_seen[d]), 128'(exp_q[0].ncol));
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
              chk_rdy[d] = 1'b1;
              last_hs[d] = cyc;
            end
          end
        end else if (chk_rdy[d]) begin
          check("o_ready_after_hs", 128'(ordy[d]), 128'd1);
          chk_rdy[d] = 1'b0;
        end
        vprev[d] = ovld[d];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) irdy = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'b00;
  endtask

  task automatic wait_ready(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ordy[d]) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) check("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic send(input int d, input logic [127:0] s, input logic b,
                      input logic [127:0] e, input int lat, input int nc);
    exp_t x;
    x.data = e; x.lat = lat; x.ncol = nc;
    exp_q.push_back(x);
    ist[d] = s; byp[d] = b; vld[d] = 1'b1;
    wait_ready(d);
    tick();
    vld[d] = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) check("drain_timeout", 128'(exp_q.size()), 128'd0);
    tick(); tick();
  endtask

  task automatic check_cols(input int d, input logic [127:0] s);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("col_valid_seq", 128'(cvld[d]), 128'd1);
      check("col_seq", 128'(col[d]), 128'(s[(3-k)*32 +: 32]));
    end
  endtask

  task automatic check_reset_outs(input int d);
    check("rst_o_ready", 128'(ordy[d]), 128'd1);
    check("rst_o_valid", 128'(ovld[d]), 128'd0);
    check("rst_o_col_valid", 128'(cvld[d]), 128'd0);
    check("rst_o_col", 128'(col[d]), 128'd0);
    check("rst_o_state", ost[d], 128'd0);
  endtask

  logic [127:0] vin  = 128'hdb135345f20a225c01010101c6c6c6c6;
  logic [127:0] vout = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  initial begin
    logic [127:0] s, s2;
    logic         b;
    int           acc2;
    bit           ok;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_reset_outs(d);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // FIPS-197 vector, COL_LAT=1 then COL_LAT=3
    send(0, vin, 1'b0, vout, 6, 4);
    check_cols(0, vin);
    drain();
    send(1, vin, 1'b0, vout, 8, 4);
    check_cols(1, vin);
    drain();

    // bypass
    send(0, vin, 1'b1, vin, 1, 0);
    drain();
    send(1, vin, 1'b1, vin, 1, 0);
    drain();

    // backpressure: monitor checks stability and o_ready each held cycle
    irdy[0] = 1'b0;
    send(0, vin, 1'b0, vout, 6, 4);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ovld[0]) begin ok = 1'b1; break; end
    end
    if (!ok) check("bp_valid_timeout", 128'd0, 128'd1);
    repeat (10) tick();
    irdy[0] = 1'b1;
    drain();

    // reset during issue cycle k=2
    send(0, vin, 1'b0, vout, 6, 4);
    tick();
    tick();
    check("pre_rst_issue", 128'(cvld[0]), 128'd1);
    rst = 1'b0;
    #1;
    check_reset_outs(0);
    exp_q.delete();
    acc_q.delete();
    vprev = '0;
    chk_rdy = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    send(0, vin, 1'b0, vout, 6, 4);
    drain();

    // back-to-back with i_valid held high
    s  = {$urandom, $urandom, $urandom, $urandom};
    s2 = {$urandom, $urandom, $urandom, $urandom};
    begin
      exp_t x;
      x.data = mix_state(s); x.lat = 6; x.ncol = 4;
      exp_q.push_back(x);
      ist[0] = s; byp[0] = 1'b0; vld[0] = 1'b1;
      wait_ready(0);
      tick();
      ist[0] = s2;
      x.data = mix_state(s2);
      exp_q.push_back(x);
      wait_ready(0);
      acc2 = cyc;
      check("b2b_accept_cycle", 128'(acc2), 128'(last_hs[0] + 1));
      tick();
      vld[0] = 1'b0;
      drain();
    end

    // randomized traffic with random downstream stalls
    rnd_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 15; n++) begin
        s = {$urandom, $urandom, $urandom, $urandom};
        b = ($urandom_range(0, 3) == 0);
        send(d, s, b, b ? s : mix_state(s), b ? 1 : (d == 0 ? 6 : 8), b ? 0 : 4);
        repeat ($urandom_range(0, 2)) tick();
      end
      drain();
    end
    rnd_en = 1'b0;
    irdy = '1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mixcolumns_seq.md
Name: mixcolumns_seq

Overview:
Sequencer that applies AES MixColumns to a full 128-bit state using one shared single-column mixing unit.
- Accepts a state over a valid/ready handshake.
- Issues the four 32-bit columns to the column unit on consecutive cycles.
- Collects the results after the unit's fixed latency and presents the reassembled state over a second valid/ready handshake.
- A bypass input skips mixing for the final AES round.
- Sits between the ShiftRows stage and AddRoundKey in the round datapath.

Parameters:
- COL_LAT, 1, column unit latency in cycles from o_col issue to i_col_res valid; legal range 1..4.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- i_valid  input  1  input state valid.
- o_ready  output  1  block can accept a state.
- i_bypass  input  1  sampled with i_state; 1 = pass through unmixed.
- i_state  input  128  state; column 0 = [127:96], column 3 = [31:0].
- o_col  output  32  column presented to the shared unit.
- o_col_valid  output  1  o_col carries a live column this cycle.
- i_col_res  input  32  column unit result, valid COL_LAT cycles after issue.
- o_valid  output  1  o_state valid.
- i_ready  input  1  downstream accepts o_state.
- o_state  output  128  mixed (or bypassed) state, same column order as input.

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE, issue and capture counters to 0, latency valid pipeline cleared.
- Output reset values: o_ready=1, o_valid=0, o_col_valid=0, o_col=0, o_state=0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: o_ready=1; all other handshakes low.
  - Accept on a rising edge with i_valid && o_ready; i_state and i_bypass are registered.
  - i_bypass=1: load o_state directly from i_state and go to DONE.
  - i_bypass=0: go to ISSUE.
- ISSUE: o_ready=0. Occupies exactly 4 cycles.
  - In issue cycle k (k=0..3), o_col = column k of the registered state and o_col_valid=1.
  - The 2-bit issue counter increments each cycle; after k=3 the FSM goes to WAIT.
- Capture:
  - An o_col_valid delay line COL_LAT deep marks when i_col_res is live.
  - On each marked edge, i_col_res is written into o_state column j and the 2-bit capture counter increments.
  - i_col_res is ignored on unmarked cycles.
- WAIT: hold until the 4th capture (j=3). On that edge, go to DONE.
- DONE: o_valid=1 and o_state stable until i_valid-independent handshake completes (o_valid && i_ready). Then go to IDLE, and o_ready=1 in the next cycle.
- No overlap: the next state cannot be accepted in the same cycle DONE completes.
- Latency, accept at edge T:
  - Issues occupy cycles T+1..T+4.
  - o_valid rises in cycle T+5+COL_LAT (T+6 for COL_LAT=1).
  - Bypass: o_valid in cycle T+1.
- Backpressure: i_ready low holds DONE indefinitely; o_state must not change.
- Reset mid-operation: all in-flight issues are abandoned, and results returning after reset are ignored because the delay line is cleared.
- o_col is 0 whenever o_col_valid=0.

Test Plan:
1. Mixing, FIPS-197 vector:
   - Stimulus: i_state=db135345f20a225c01010101c6c6c6c6, i_bypass=0; bench models the column unit with COL_LAT=1; i_ready=1.
   - Response: o_col sequence db135345, f20a225c, 01010101, c6c6c6c6 on 4 consecutive cycles; o_state=8e4da1bc9fdc589d01010101c6c6c6c6; o_valid exactly 6 cycles after accept.
2. Bypass:
   - Stimulus: same state with i_bypass=1.
   - Response: no o_col_valid pulses; o_state equals the input 1 cycle after accept.
3. Backpressure:
   - Stimulus: vector 1 with i_ready held 0 for 10 cycles after o_valid.
   - Response: o_state stable, o_ready=0 throughout; o_ready=1 the cycle after the i_ready handshake.
4. Latency parameter:
   - Stimulus: COL_LAT=3 with the bench unit delayed to match.
   - Response: same o_state as scenario 1; o_valid 8 cycles after accept.
5. Reset mid-operation:
   - Stimulus: deassert rst during ISSUE (k=2).
   - Response: outputs immediately at reset values. After release, a new vector 1 run produces the correct result with no stale column in o_state.
6. Back-to-back:
   - Stimulus: two states with i_valid held high.
   - Response: the second is accepted only in the cycle after the first output handshake, and both results are correct.
